// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the data-processing issue controller:
// ALU opcodes, ARM condition encodings, CPSR flag positions and FSM states.
package alu_issue_ctrl_pkg;

  localparam int                  WordWidth = 32;
  localparam logic [WordWidth-1:0] WordZero = {WordWidth{1'b0}};

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_EOR = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_RSB = 4'd3;
  localparam logic [3:0] ALU_ADD = 4'd4;
  localparam logic [3:0] ALU_ADC = 4'd5;
  localparam logic [3:0] ALU_SBC = 4'd6;
  localparam logic [3:0] ALU_RSC = 4'd7;
  localparam logic [3:0] ALU_TST = 4'd8;
  localparam logic [3:0] ALU_TEQ = 4'd9;
  localparam logic [3:0] ALU_CMP = 4'd10;
  localparam logic [3:0] ALU_CMN = 4'd11;
  localparam logic [3:0] ALU_ORR = 4'd12;
  localparam logic [3:0] ALU_MOV = 4'd13;
  localparam logic [3:0] ALU_BIC = 4'd14;
  localparam logic [3:0] ALU_MVN = 4'd15;

  localparam logic [3:0] Cond_EQ = 4'h0;
  localparam logic [3:0] Cond_NE = 4'h1;
  localparam logic [3:0] Cond_CS = 4'h2;
  localparam logic [3:0] Cond_CC = 4'h3;
  localparam logic [3:0] Cond_MI = 4'h4;
  localparam logic [3:0] Cond_PL = 4'h5;
  localparam logic [3:0] Cond_VS = 4'h6;
  localparam logic [3:0] Cond_VC = 4'h7;
  localparam logic [3:0] Cond_HI = 4'h8;
  localparam logic [3:0] Cond_LS = 4'h9;
  localparam logic [3:0] Cond_GE = 4'hA;
  localparam logic [3:0] Cond_LT = 4'hB;
  localparam logic [3:0] Cond_GT = 4'hC;
  localparam logic [3:0] Cond_LE = 4'hD;
  localparam logic [3:0] Cond_AL = 4'hE;
  localparam logic [3:0] Cond_NV = 4'hF;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Carry-consuming arithmetic takes CPSR C instead of the shifter carry.
  function automatic logic uses_cpsr_carry(input logic [3:0] opc);
    return (opc == ALU_ADC) || (opc == ALU_SBC) || (opc == ALU_RSC);
  endfunction

  function automatic logic is_compare_op(input logic [3:0] opc);
    return (opc[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_check.sv
// ARM condition-field evaluator against CNZV flags; shared by the execute,
// load/store and branch controllers.
module alu_issue_ctrl_cond_check
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] in_Cond,
  input  logic [3:0] in_CNZV,
  output logic       out_Pass
);

  logic c_s, n_s, z_s, v_s;

  assign c_s = in_CNZV[FLAG_C];
  assign n_s = in_CNZV[FLAG_N];
  assign z_s = in_CNZV[FLAG_Z];
  assign v_s = in_CNZV[FLAG_V];

  // Condition decode; NV never passes.
  always_comb begin
    out_Pass = 1'b0;
    case (in_Cond)
      Cond_EQ: out_Pass = z_s;
      Cond_NE: out_Pass = !z_s;
      Cond_CS: out_Pass = c_s;
      Cond_CC: out_Pass = !c_s;
      Cond_MI: out_Pass = n_s;
      Cond_PL: out_Pass = !n_s;
      Cond_VS: out_Pass = v_s;
      Cond_VC: out_Pass = !v_s;
      Cond_HI: out_Pass = c_s && !z_s;
      Cond_LS: out_Pass = !c_s || z_s;
      Cond_GE: out_Pass = (n_s == v_s);
      Cond_LT: out_Pass = (n_s != v_s);
      Cond_GT: out_Pass = !z_s && (n_s == v_s);
      Cond_LE: out_Pass = z_s || (n_s != v_s);
      Cond_AL: out_Pass = 1'b1;
      default: out_Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller: condition check, registered ALU drive, CPSR
// ownership, writeback handshake and PC-write flush.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int         WIDTH  = WordWidth,
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic             in_Clk,
  input  logic             in_Rst_n,
  input  logic             in_Valid,
  output logic             out_Ready,
  input  logic [3:0]       in_Cond,
  input  logic [3:0]       in_Opcode,
  input  logic             in_Set_cond,
  input  logic [3:0]       in_Rd,
  input  logic [WIDTH-1:0] in_Rn,
  input  logic [WIDTH-1:0] in_Op2,
  input  logic             in_Barrel_carry,
  output logic [WIDTH-1:0] out_Alu_Rn,
  output logic [WIDTH-1:0] out_Alu_Op2,
  output logic             out_Alu_Carry,
  output logic [3:0]       out_Alu_Opcode,
  output logic             out_Alu_Set_cond,
  output logic [3:0]       out_Alu_CNZV,
  input  logic [WIDTH-1:0] in_Alu_Y,
  input  logic [3:0]       in_Alu_CNZV,
  output logic             out_Wb_valid,
  input  logic             in_Wb_ready,
  output logic [3:0]       out_Wb_addr,
  output logic [WIDTH-1:0] out_Wb_data,
  output logic             out_Flush,
  output logic [3:0]       out_CNZV
);

  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] rn_q, rn_d, op2_q, op2_d, result_q, result_d;
  logic             carry_q, carry_d, s_q, s_d;
  logic [3:0]       opcode_q, opcode_d, rd_q, rd_d;
  logic             cond_pass_s;

  alu_issue_ctrl_cond_check u_cond_check (
    .in_Cond  (in_Cond),
    .in_CNZV  (flags_q),
    .out_Pass (cond_pass_s)
  );

  // Next-state and datapath latch decisions.
  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    rn_d     = rn_q;
    op2_d    = op2_q;
    result_d = result_q;
    carry_d  = carry_q;
    s_d      = s_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (in_Valid && cond_pass_s) begin
          rn_d     = in_Rn;
          op2_d    = in_Op2;
          opcode_d = in_Opcode;
          s_d      = in_Set_cond;
          rd_d     = in_Rd;
          carry_d  = uses_cpsr_carry(in_Opcode) ? flags_q[FLAG_C] : in_Barrel_carry;
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d = in_Alu_Y;
        if (s_q) begin
          flags_d = in_Alu_CNZV;
        end else begin
          flags_d = flags_q;
        end
        state_d = is_compare_op(opcode_q) ? ST_IDLE : ST_WB;
      end
      ST_WB: begin
        if (in_Wb_ready) begin
          state_d = (rd_q == PC_REG) ? ST_FLUSH : ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, CPSR and latched-operand registers.
  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      state_q  <= ST_IDLE;
      flags_q  <= 4'b0000;
      rn_q     <= WordZero[WIDTH-1:0];
      op2_q    <= WordZero[WIDTH-1:0];
      result_q <= WordZero[WIDTH-1:0];
      carry_q  <= 1'b0;
      s_q      <= 1'b0;
      opcode_q <= 4'd0;
      rd_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      rn_q     <= rn_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      s_q      <= s_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
    end
  end

  assign out_Ready        = (state_q == ST_IDLE);
  assign out_Wb_valid     = (state_q == ST_WB);
  assign out_Flush        = (state_q == ST_FLUSH);
  assign out_Alu_Rn       = rn_q;
  assign out_Alu_Op2      = op2_q;
  assign out_Alu_Carry    = carry_q;
  assign out_Alu_Opcode   = opcode_q;
  assign out_Alu_Set_cond = s_q;
  assign out_Alu_CNZV     = flags_q;
  assign out_CNZV         = flags_q;
  assign out_Wb_addr      = rd_q;
  assign out_Wb_data      = result_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage controller that sequences the combinational data-processing ALU.
- Accepts one decoded data-processing instruction at a time over a valid/ready handshake and evaluates its ARM condition field against the CPSR flags, which this block owns.
- Drives the ALU with registered operands, captures the result and updates flags when S is set.
- Presents the writeback to the register file and issues a one-cycle pipeline flush when Rd is the PC (R15).

Parameters:
- WIDTH, `WordWidth (32), datapath word width.
- PC_REG, 4'd15, register index that triggers a flush on writeback.

Ports:
- in_Clk  in  1  clock, rising edge.
- in_Rst_n  in  1  asynchronous, active-low reset.
- in_Valid  in  1  decoded instruction present.
- out_Ready  out  1  controller can accept an instruction.
- in_Cond  in  4  ARM condition field.
- in_Opcode  in  4  ALU opcode. Encoding: AND0 EOR1 SUB2 RSB3 ADD4 ADC5 SBC6 RSC7 TST8 TEQ9 CMP10 CMN11 ORR12 MOV13 BIC14 MVN15.
- in_Set_cond  in  1  S bit.
- in_Rd  in  4  destination register index.
- in_Rn  in  WIDTH  operand 1 value.
- in_Op2  in  WIDTH  shifted-register or immediate operand.
- in_Barrel_carry  in  1  shifter carry-out.
- out_Alu_Rn, out_Alu_Op2  out  WIDTH  ALU operands.
- out_Alu_Carry  out  1  drives the ALU barrel-carry input.
- out_Alu_Opcode  out  4; out_Alu_Set_cond  out  1; out_Alu_CNZV  out  4  ALU controls and current flags.
- in_Alu_Y  in  WIDTH; in_Alu_CNZV  in  4  ALU result and flags.
- out_Wb_valid  out  1; in_Wb_ready  in  1  writeback handshake.
- out_Wb_addr  out  4; out_Wb_data  out  WIDTH  writeback target and value.
- out_Flush  out  1  one-cycle flush pulse on a PC write.
- out_CNZV  out  4  CPSR flags: [3]=C, [2]=N, [1]=Z, [0]=V.

Behaviour:
- Reset (asynchronous, in_Rst_n=0):
  - state=IDLE; flags=4'b0000; operand registers=0.
  - out_Ready=1, out_Wb_valid=0, out_Flush=0.
  - out_Wb_addr=0, out_Wb_data=0.
  - Reset mid-operation drops any pending result and writeback.
- States:
  - IDLE: out_Ready=1. On accept (in_Valid & out_Ready), evaluate the condition against the current flags.
    - Pass: latch opcode, S, Rd, Rn, Op2 and the carry selection; go to EXEC.
    - Fail: discard the instruction, stay in IDLE, flags unchanged.
  - EXEC: ALU outputs are driven from the latched registers. At the end of the cycle, capture in_Alu_Y. If S=1, flags <= in_Alu_CNZV.
    - Opcode 8-11 → IDLE (no writeback).
    - Otherwise → WB.
  - WB: out_Wb_valid=1 with addr and data stable until in_Wb_ready=1.
    - On handshake: if Rd==PC_REG go to FLUSH, else IDLE.
  - FLUSH: out_Flush=1 for exactly one cycle, then IDLE.
- Condition codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V); AL 1.
  - 4'hF (NV): never passes.
- Carry selection (latched at accept):
  - ADC, SBC, RSC: out_Alu_Carry = CPSR C.
  - All other opcodes: out_Alu_Carry = in_Barrel_carry.
- Other ALU drive rules:
  - out_Alu_CNZV = current flags in every state.
  - In IDLE/WB/FLUSH, ALU operands hold their last latched values; their outputs are ignored.
- Flag update and forwarding:
  - Flags update only in EXEC, and only when S=1.
  - A failed condition never touches the flags.
  - An instruction accepted in the cycle after EXEC sees the updated flags (flags are registered; no bypass is needed because IDLE follows).
- Latency:
  - Non-writing instruction: accept → flags valid 2 cycles later.
  - Writing instruction: out_Wb_valid is asserted in cycle accept+2. The next accept can happen no earlier than the cycle after the WB handshake, or after FLUSH.
- Boundaries:
  - in_Valid is ignored outside IDLE.
  - out_Wb_valid must never drop before in_Wb_ready.
  - in_Wb_ready asserted while out_Wb_valid=0 has no effect.

Decomposition:
- Shared package/defines: reuse the ALUType opcode defines and the WordWidth/WordZero constants.
- Add to the package: Cond_* condition encodings, the state encoding (IDLE, EXEC, WB, FLUSH) and the flag bit indices.
- One natural sub-module: cond_check (combinational; inputs in_Cond and in_CNZV, output pass). It is reusable by load/store and branch control.

Test Plan:
- Reset with in_Rst_n=0 mid-WB → out_Wb_valid=0, out_CNZV=0, out_Ready=1 immediately (asynchronous).
- ADDS Rd=1, Rn=0xFFFFFFFF, Op2=1, cond AL; ALU model returns Y=0, CNZV=1010 → WB addr=1 data=0; out_CNZV=4'b1010 after EXEC.
- CMP with S=1 (opcode 10), Rn=5, Op2=5 → no out_Wb_valid, Z set; a following MOVEQ R2,#7 writes 7; MOVNE is dropped with out_Ready held at 1.
- ADC with CPSR C=1 and in_Barrel_carry=0 → out_Alu_Carry=1 during EXEC; with ORRS and in_Barrel_carry=1 → out_Alu_Carry=1 regardless of C.
- MOV R15,#0x100 with in_Wb_ready held low 3 cycles → out_Wb_valid stable for 4 cycles, then out_Flush high exactly one cycle.
- cond=4'hF with in_Valid=1 → never executes; flags unchanged; no writeback.
